// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and constants for the register file slice
package register_file_pkg;

  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] RegAddr;
  typedef logic [DATA_WIDTH-1:0] BasicData;

  localparam RegAddr ZERO_REG = 5'd0;

  typedef struct packed {
    logic   isRdWrite;
    RegAddr rdAddr;
  } RDCtrl;

  // True when this cycle's writeback targets a real register at the given read address.
  function automatic logic wb_hits(input RegAddr addr, input RDCtrl ctrl);
    return ctrl.isRdWrite && (ctrl.rdAddr == addr) && (addr != ZERO_REG);
  endfunction

  function automatic logic wb_commits(input RDCtrl ctrl);
    return ctrl.isRdWrite && (ctrl.rdAddr != ZERO_REG);
  endfunction

endpackage

// File: rtl/register_file_reg_scoreboard.sv
// rtl/register_file_reg_scoreboard.sv - pending-write busy bits with flush/clear/set priority
module reg_scoreboard #(
  parameter int REG_NUM = register_file_pkg::REG_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  register_file_pkg::RDCtrl  rdCtrl,
  input  logic                      issueValid,
  input  register_file_pkg::RegAddr issueRdAddr,
  input  register_file_pkg::RegAddr rs1Addr,
  input  register_file_pkg::RegAddr rs2Addr,
  output logic                      rs1Busy,
  output logic                      rs2Busy
);
  import register_file_pkg::*;

  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_next;

  // Issue is applied after the writeback clear so a same-cycle reissue stays pending.
  always_comb begin
    w_busy_next = r_busy;
    if (flush) begin
      w_busy_next = '0;
    end else begin
      if (wb_commits(rdCtrl)) begin
        w_busy_next[rdCtrl.rdAddr] = 1'b0;
      end
      if (issueValid && (issueRdAddr != ZERO_REG)) begin
        w_busy_next[issueRdAddr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // A writeback landing this cycle satisfies the reader, so it is masked out.
  always_comb begin
    rs1Busy = rst && (rs1Addr != ZERO_REG) && r_busy[rs1Addr] && !wb_hits(rs1Addr, rdCtrl);
    rs2Busy = rst && (rs2Addr != ZERO_REG) && r_busy[rs2Addr] && !wb_hits(rs2Addr, rdCtrl);
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - integer register file with write bypass and RAW scoreboard
module register_file #(
  parameter int REG_NUM    = register_file_pkg::REG_NUM,
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  register_file_pkg::RegAddr rs1Addr,
  input  register_file_pkg::RegAddr rs2Addr,
  output logic [DATA_WIDTH-1:0]     rs1Data,
  output logic [DATA_WIDTH-1:0]     rs2Data,
  input  register_file_pkg::RDCtrl  rdCtrl,
  input  logic [DATA_WIDTH-1:0]     wData,
  input  logic                      issueValid,
  input  register_file_pkg::RegAddr issueRdAddr,
  input  logic                      flush,
  output logic                      rs1Busy,
  output logic                      rs2Busy
);
  import register_file_pkg::*;

  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

  // Entry 0 is never written; reads of x0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_commits(rdCtrl)) begin
      r_regs[rdCtrl.rdAddr] <= wData;
    end
  end

  always_comb begin
    rs1Data = '0;
    if (rst && (rs1Addr != ZERO_REG)) begin
      rs1Data = wb_hits(rs1Addr, rdCtrl) ? wData : r_regs[rs1Addr];
    end
  end

  always_comb begin
    rs2Data = '0;
    if (rst && (rs2Addr != ZERO_REG)) begin
      rs2Data = wb_hits(rs2Addr, rdCtrl) ? wData : r_regs[rs2Addr];
    end
  end

  reg_scoreboard #(
    .REG_NUM(REG_NUM)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rdCtrl      (rdCtrl),
    .issueValid  (issueValid),
    .issueRdAddr (issueRdAddr),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rs1Busy     (rs1Busy),
    .rs2Busy     (rs2Busy)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - vector-table bench for register_file with an expectation queue
module tb_register_file;
  import register_file_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  RegAddr   rs1Addr, rs2Addr, issueRdAddr;
  BasicData rs1Data, rs2Data, wData;
  RDCtrl    rdCtrl;
  logic     issueValid, flush, rs1Busy, rs2Busy;

  always #5 clk = ~clk;

  register_file dut (
    .clk         (clk),
    .rst         (rst),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rs1Data     (rs1Data),
    .rs2Data     (rs2Data),
    .rdCtrl      (rdCtrl),
    .wData       (wData),
    .issueValid  (issueValid),
    .issueRdAddr (issueRdAddr),
    .flush       (flush),
    .rs1Busy     (rs1Busy),
    .rs2Busy     (rs2Busy)
  );

  typedef struct {
    logic     rst;
    RegAddr   rs1, rs2;
    logic     wr;
    RegAddr   rd;
    BasicData wd;
    logic     iv;
    RegAddr   ird;
    logic     fl;
    logic     chk;
    BasicData e1, e2;
    logic     b1, b2;
  } vec_t;

  typedef struct {
    BasicData d1, d2;
    logic     b1, b2;
    int       idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input int a1, input int a2, input logic wr,
                              input int rd, input logic [31:0] wd, input logic iv, input int ird,
                              input logic fl, input logic chk, input logic [31:0] e1,
                              input logic [31:0] e2, input logic b1, input logic b2);
    vec_t v;
    v.rst = r;  v.rs1 = RegAddr'(a1); v.rs2 = RegAddr'(a2);
    v.wr = wr;  v.rd = RegAddr'(rd);  v.wd = wd;
    v.iv = iv;  v.ird = RegAddr'(ird); v.fl = fl; v.chk = chk;
    v.e1 = e1;  v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    rst = v.rst; rs1Addr = v.rs1; rs2Addr = v.rs2;
    rdCtrl.isRdWrite = v.wr; rdCtrl.rdAddr = v.rd; wData = v.wd;
    issueValid = v.iv; issueRdAddr = v.ird; flush = v.fl;
    if (v.chk) sb.push_back('{v.e1, v.e2, v.b1, v.b2, idx});
    @(negedge clk);
    if (v.chk) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (rs1Data !== e.d1) begin
        n_err++;
        $display("FAIL vec%0d rs1Data actual=%h expected=%h", e.idx, rs1Data, e.d1);
      end
      if (rs2Data !== e.d2) begin
        n_err++;
        $display("FAIL vec%0d rs2Data actual=%h expected=%h", e.idx, rs2Data, e.d2);
      end
      if (rs1Busy !== e.b1) begin
        n_err++;
        $display("FAIL vec%0d rs1Busy actual=%b expected=%b", e.idx, rs1Busy, e.b1);
      end
      if (rs2Busy !== e.b2) begin
        n_err++;
        $display("FAIL vec%0d rs2Busy actual=%b expected=%b", e.idx, rs2Busy, e.b2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rs1Addr = '0; rs2Addr = '0; rdCtrl = '0; wData = '0;
    issueValid = 1'b0; issueRdAddr = '0; flush = 1'b0;

    // rst rs1 rs2 wr rd wdata iv ird fl chk exp1 exp2 b1 b2
    vecs.push_back(mk(0,  5,  5, 1,  5, 32'h0000DEAD, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,  5,  5, 1,  5, 32'h0000DEAD, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  5,  0, 0,  0, 0,            0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1,  7,  0, 1,  7, 32'h12345678, 0,  0, 0, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(1,  7,  7, 0,  0, 0,            0,  0, 0, 1, 32'h12345678, 32'h12345678, 0, 0));
    vecs.push_back(mk(1,  0,  7, 1,  0, 32'h0000FFFF, 0,  0, 0, 1, 0, 32'h12345678, 0, 0));
    vecs.push_back(mk(1,  0,  0, 0,  0, 0,            0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1,  3,  0, 1,  3, 32'h11,       0,  0, 0, 1, 32'h11, 0, 0, 0));
    vecs.push_back(mk(1,  3,  3, 1,  3, 32'h22,       0,  0, 0, 1, 32'h22, 32'h22, 0, 0));
    vecs.push_back(mk(1,  0,  3, 0,  0, 0,            0,  0, 0, 1, 0, 32'h22, 0, 0));
    vecs.push_back(mk(1,  9,  0, 0,  0, 0,            1,  9, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1,  9,  0, 0,  0, 0,            0,  0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1,  9,  9, 1,  9, 32'h5A,       0,  0, 0, 1, 32'h5A, 32'h5A, 0, 0));
    vecs.push_back(mk(1,  9,  0, 0,  0, 0,            0,  0, 0, 1, 32'h5A, 0, 0, 0));
    vecs.push_back(mk(1,  4,  0, 1,  4, 32'h44,       1,  4, 0, 1, 32'h44, 0, 0, 0));
    vecs.push_back(mk(1,  0,  4, 0,  0, 0,            1,  0, 0, 1, 0, 32'h44, 0, 1));
    vecs.push_back(mk(1,  0,  4, 0,  0, 0,            0,  0, 0, 1, 0, 32'h44, 0, 1));
    vecs.push_back(mk(1, 10, 11, 0,  0, 0,            1, 10, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 10, 11, 0,  0, 0,            1, 11, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 10, 11, 1, 10, 32'h77,       1, 12, 1, 1, 32'h77, 0, 0, 1));
    vecs.push_back(mk(1, 10, 11, 0,  0, 0,            0,  0, 0, 1, 32'h77, 0, 0, 0));
    vecs.push_back(mk(1, 12,  4, 0,  0, 0,            0,  0, 0, 1, 0, 32'h44, 0, 0));
    vecs.push_back(mk(1, 31,  0, 1, 31, 32'hA5A5A5A5, 0,  0, 0, 1, 32'hA5A5A5A5, 0, 0, 0));
    vecs.push_back(mk(1, 31,  7, 0,  0, 0,            0,  0, 0, 1, 32'hA5A5A5A5, 32'h12345678, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reissue to a busy register, then writeback clears it while another issue lands.
    apply(mk(1, 20,  0, 0,  0, 0,          1, 20, 0, 1, 0, 0, 0, 0), 100);
    apply(mk(1, 20,  0, 0,  0, 0,          1, 20, 0, 1, 0, 0, 1, 0), 101);
    apply(mk(1, 20,  0, 0,  0, 0,          0,  0, 0, 1, 0, 0, 1, 0), 102);
    apply(mk(1, 20, 21, 1, 20, 32'hBEEF,   1, 21, 0, 1, 32'hBEEF, 0, 0, 0), 103);
    apply(mk(1, 20, 21, 0,  0, 0,          0,  0, 0, 1, 32'hBEEF, 0, 0, 1), 104);

    // Mid-run reset wipes data and busy bits even with a write and issue pending.
    apply(mk(0,  7, 21, 1,  7, 32'hCAFE,   1, 22, 0, 0, 0, 0, 0, 0), 105);
    apply(mk(1,  7, 21, 0,  0, 0,          0,  0, 0, 1, 0, 0, 0, 0), 106);
    apply(mk(1, 31, 22, 0,  0, 0,          0,  0, 0, 1, 0, 0, 0, 0), 107);
    apply(mk(1, 20,  9, 0,  0, 0,          0,  0, 0, 1, 0, 0, 0, 0), 108);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural integer register file: the responder end of the decode-read / writeback-write register interface.
- Provides two combinational read ports (rs1, rs2) to DecodeStage and one write port from WriteBackStage.
- Adds write-to-read bypass and a per-register pending-write scoreboard, so decode can detect RAW hazards against instructions still in flight.
- x0 is hardwired to zero.

Parameters:
- REG_NUM, 32, number of architectural registers; must equal 2**$bits(RegAddr).
- DATA_WIDTH, 32, register width; must equal $bits(BasicData).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (reset when rst==0 at a rising edge).
- rs1Addr  input  5 (RegAddr)  read port 1 address.
- rs2Addr  input  5 (RegAddr)  read port 2 address.
- rs1Data  output  32 (BasicData)  read port 1 data, combinational.
- rs2Data  output  32 (BasicData)  read port 2 data, combinational.
- rdCtrl  input  RDCtrl {isRdWrite 1, rdAddr 5}  writeback control.
- wData  input  32 (BasicData)  writeback data.
- issueValid  input  1  decode issues an instruction that will write issueRdAddr.
- issueRdAddr  input  5  destination of the issuing instruction.
- flush  input  1  pipeline flush; squashes all in-flight writers.
- rs1Busy  output  1  rs1Addr has a pending write not yet available.
- rs2Busy  output  1  rs2Addr has a pending write not yet available.

Behaviour:
- State: regs[REG_NUM] x DATA_WIDTH; busy[REG_NUM] bits.
- Reset (rst==0 at edge): all regs <= 0, all busy <= 0. Reset overrides write/issue/flush that cycle.
- Reset outputs: rs*Data read 0 for any address, rs*Busy = 0.
- Write: when isRdWrite && rdAddr!=0 at edge, regs[rdAddr] <= wData. Writes to x0 are ignored with no state change.
- Read (0-cycle latency):
  - Address 0 -> 0.
  - Else if isRdWrite && rdAddr==rsAddr -> wData (bypass).
  - Else -> regs[rsAddr].
  - Both ports are independent; same address on both ports returns identical data.
- Busy output:
  - rsBusy = busy[rsAddr] && !(isRdWrite && rdAddr==rsAddr).
  - Forced to 0 for address 0.
  - Reflects state before this cycle's issue, so an instruction never stalls on itself.
- Scoreboard update at edge, in priority order:
  1. flush==1: all busy <= 0. issueValid is ignored. The write still commits to regs.
  2. Writeback with rdAddr!=0: busy[rdAddr] <= 0.
  3. issueValid with issueRdAddr!=0: busy[issueRdAddr] <= 1. Issue beats writeback on the same address in the same cycle, so the bit ends at 1.
- Issue to x0 never sets busy. Re-issue to an already-busy register leaves it busy. The pipeline is in-order with a single writer in flight per register; a single bit suffices.
- No X propagation: all outputs are driven for every input combination after reset.

Decomposition:
- BasicTypes (existing): RegAddr, BasicData, REG_NUM, DATA_WIDTH.
- PipelineTypes (existing): RDCtrl {isRdWrite, rdAddr}.
- New constant in BasicTypes: ZERO_REG = 5'd0.
- Sub-module reg_scoreboard: busy vector, flush/clear/set priority, rs1Busy/rs2Busy lookup.
- The data array and bypass stay in register_file.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with isRdWrite=1, rdAddr=5, wData=0xDEAD. Release, read rs1Addr=5 -> rs1Data=0, rs1Busy=0.
2. Write and read back: write x7=0x12345678. Next cycle rs1Addr=7, rs2Addr=7 -> both 0x12345678. Write x0=0xFFFF, then read x0 -> 0.
3. Bypass: x3 holds 0x11. In the same cycle, write x3=0x22 with rs2Addr=3 -> rs2Data=0x22 combinationally. Next cycle, with no write -> 0x22.
4. Scoreboard: issue rd=9 -> next cycle rs1Addr=9 gives rs1Busy=1. Writeback x9=0x5A with rs1Addr=9 in the same cycle -> rs1Busy=0, rs1Data=0x5A. Next cycle rs1Busy=0.
5. Same-cycle issue and writeback, both rd=4 -> busy[4] ends at 1. Issue rd=0 -> rs1Addr=0 gives rs1Busy=0.
6. Flush: issue rd=10 and rd=11 on consecutive cycles. Then assert flush together with issueValid rd=12 and a write of x10=0x77. Next cycle: busy for 10/11/12 all 0, x10 reads 0x77.
